// File: rtl/cam_i2c_master.sv
// cam_i2c_master: camera-sensor I2C master clocked from pixclk.
// SCL/SDA waveforms are built from quarter-bit ticks of an internal divider.
module cam_i2c_master #(
    parameter int CLK_HZ         = 25_000_000,
    parameter int I2C_HZ         = 400_000,
    parameter int REG_ADDR_BYTES = 2,
    parameter int DATA_BYTES     = 1
) (
    input  logic                      pixclk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      rw,
    input  logic [6:0]                slave_addr,
    input  logic [8*REG_ADDR_BYTES-1:0] register_in,
    input  logic [8*DATA_BYTES-1:0]   datain,
    output logic [8*DATA_BYTES-1:0]   dataout,
    output logic                      busy,
    output logic                      done,
    output logic                      nack,
    output logic                      scl,
    inout  wire                       sda
);
    localparam int DIV = (CLK_HZ + 4 * I2C_HZ - 1) / (4 * I2C_HZ);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW  = 8 * REG_ADDR_BYTES;
    localparam int DW  = 8 * DATA_BYTES;
    localparam logic [DCW-1:0] DIV_MAX  = DCW'(DIV - 1);
    localparam logic [1:0]     REG_LAST = 2'(REG_ADDR_BYTES - 1);
    localparam logic [1:0]     DAT_LAST = 2'(DATA_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, REG, DATA_W, RSTART,
        ADDR_R, DATA_R, ACK, MACK, STOP
    } state_t;

    state_t         state, state_n;
    state_t         ret_st, ret_n;
    logic [DCW-1:0] div_cnt, div_n;
    logic [1:0]     qtr, qtr_n;
    logic [2:0]     bit_cnt, bit_n;
    logic [1:0]     byte_cnt, byte_n;
    logic [7:0]     tx_sh, tx_n;
    logic [RW-1:0]  reg_sh, reg_n;
    logic [DW-1:0]  dat_sh, dat_n;
    logic [DW-1:0]  rx_sh, rx_n;
    logic [DW-1:0]  dout_n;
    logic [6:0]     addr_q, addr_n;
    logic           rw_q, rw_n;
    logic           sda_smp, smp_n;
    logic           nack_n, done_n;
    logic           tick, bit_end;
    logic           sda_in, sda_low, scl_c;

    assign sda_in  = sda;
    assign tick    = (div_cnt == DIV_MAX);
    assign bit_end = tick && (qtr == 2'd3);

    always_ff @(posedge pixclk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ret_st   <= IDLE;
            div_cnt  <= '0;
            qtr      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx_sh    <= '0;
            reg_sh   <= '0;
            dat_sh   <= '0;
            rx_sh    <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            sda_smp  <= 1'b1;
            nack     <= 1'b0;
            done     <= 1'b0;
            dataout  <= '0;
        end else begin
            state    <= state_n;
            ret_st   <= ret_n;
            div_cnt  <= div_n;
            qtr      <= qtr_n;
            bit_cnt  <= bit_n;
            byte_cnt <= byte_n;
            tx_sh    <= tx_n;
            reg_sh   <= reg_n;
            dat_sh   <= dat_n;
            rx_sh    <= rx_n;
            addr_q   <= addr_n;
            rw_q     <= rw_n;
            sda_smp  <= smp_n;
            nack     <= nack_n;
            done     <= done_n;
            dataout  <= dout_n;
        end
    end

    always_comb begin
        state_n = state;
        ret_n   = ret_st;
        div_n   = div_cnt;
        qtr_n   = qtr;
        bit_n   = bit_cnt;
        byte_n  = byte_cnt;
        tx_n    = tx_sh;
        reg_n   = reg_sh;
        dat_n   = dat_sh;
        rx_n    = rx_sh;
        addr_n  = addr_q;
        rw_n    = rw_q;
        smp_n   = sda_smp;
        nack_n  = nack;
        done_n  = 1'b0;
        dout_n  = dataout;
        if (state == IDLE) begin
            div_n = '0;
            qtr_n = '0;
            if (start) begin
                state_n = START;
                rw_n    = rw;
                addr_n  = slave_addr;
                reg_n   = register_in;
                dat_n   = datain;
                nack_n  = 1'b0;
            end
        end else begin
            div_n = tick ? '0 : div_cnt + 1'b1;
            if (tick) qtr_n = qtr + 2'd1;
            // SDA is sampled on the first pixclk of q3
            if (qtr == 2'd3 && div_cnt == '0) smp_n = sda_in;
            if (bit_end) begin
                bit_n = bit_cnt + 3'd1;
                tx_n  = {tx_sh[6:0], 1'b0};
                unique case (state)
                    START: begin
                        state_n = ADDR;
                        tx_n    = {addr_q, 1'b0};
                        bit_n   = '0;
                    end
                    RSTART: begin
                        state_n = ADDR_R;
                        tx_n    = {addr_q, 1'b1};
                        bit_n   = '0;
                    end
                    ADDR, REG, DATA_W, ADDR_R: begin
                        if (bit_cnt == 3'd7) begin
                            ret_n   = state;
                            state_n = ACK;
                        end
                    end
                    DATA_R: begin
                        rx_n = {rx_sh[DW-2:0], sda_smp};
                        if (bit_cnt == 3'd7) state_n = MACK;
                    end
                    ACK: begin
                        bit_n = '0;
                        if (sda_smp) begin
                            nack_n  = 1'b1;
                            state_n = STOP;
                        end else begin
                            case (ret_st)
                                ADDR: begin
                                    state_n = REG;
                                    byte_n  = '0;
                                    tx_n    = reg_sh[RW-1 -: 8];
                                    reg_n   = reg_sh << 8;
                                end
                                REG: begin
                                    if (byte_cnt == REG_LAST) begin
                                        byte_n = '0;
                                        if (rw_q) begin
                                            state_n = RSTART;
                                        end else begin
                                            state_n = DATA_W;
                                            tx_n    = dat_sh[DW-1 -: 8];
                                            dat_n   = dat_sh << 8;
                                        end
                                    end else begin
                                        state_n = REG;
                                        byte_n  = byte_cnt + 2'd1;
                                        tx_n    = reg_sh[RW-1 -: 8];
                                        reg_n   = reg_sh << 8;
                                    end
                                end
                                DATA_W: begin
                                    if (byte_cnt == DAT_LAST) begin
                                        state_n = STOP;
                                    end else begin
                                        state_n = DATA_W;
                                        byte_n  = byte_cnt + 2'd1;
                                        tx_n    = dat_sh[DW-1 -: 8];
                                        dat_n   = dat_sh << 8;
                                    end
                                end
                                ADDR_R: begin
                                    state_n = DATA_R;
                                    byte_n  = '0;
                                end
                                default: state_n = STOP;
                            endcase
                        end
                    end
                    MACK: begin
                        bit_n = '0;
                        if (byte_cnt == DAT_LAST) begin
                            state_n = STOP;
                        end else begin
                            state_n = DATA_R;
                            byte_n  = byte_cnt + 2'd1;
                        end
                    end
                    STOP: begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        if (rw_q && !nack) dout_n = rx_sh;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    // bus pins decode straight from registered state so reset frees them at once
    always_comb begin
        scl_c   = 1'b1;
        sda_low = 1'b0;
        unique case (state)
            IDLE: begin
                scl_c   = 1'b1;
                sda_low = 1'b0;
            end
            START, RSTART: begin
                scl_c   = (qtr != 2'd0);
                sda_low = qtr[1];
            end
            STOP: begin
                scl_c   = (qtr != 2'd0);
                sda_low = !qtr[1];
            end
            ADDR, REG, DATA_W, ADDR_R: begin
                scl_c   = qtr[1];
                sda_low = !tx_sh[7];
            end
            DATA_R, ACK: begin
                scl_c = qtr[1];
            end
            MACK: begin
                scl_c   = qtr[1];
                sda_low = (byte_cnt != DAT_LAST);
            end
            default: begin
                scl_c   = 1'b1;
                sda_low = 1'b0;
            end
        endcase
    end

    assign scl  = scl_c;
    assign sda  = sda_low ? 1'b0 : 1'bz;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cam_i2c_master.sv
// tb_cam_i2c_master: three cam_i2c_master instances share one SDA line
// with a behavioural slave; bus traffic is checked against a byte-level model.
module tb_cam_i2c_master;
    localparam int EV_S  = 256;
    localparam int EV_P  = 257;
    localparam int EV_MA = 258;
    localparam int EV_MN = 259;

    logic        pixclk = 1'b0;
    logic        reset;
    logic        start_a, start_b, start_c;
    logic        rw;
    logic [6:0]  addr;
    logic [15:0] reg_in;
    logic [15:0] din;
    logic [7:0]  dout_a, dout_c;
    logic [15:0] dout_b;
    logic [2:0]  busy_v, done_v, nack_v, scl_v;
    wire         sda;
    logic        s_low = 1'b0;

    pullup (sda);
    assign sda = s_low ? 1'b0 : 1'bz;

    always #5 pixclk = ~pixclk;

    cam_i2c_master u_a (
        .pixclk(pixclk), .reset(reset), .start(start_a), .rw(rw),
        .slave_addr(addr), .register_in(reg_in), .datain(din[7:0]),
        .dataout(dout_a), .busy(busy_v[0]), .done(done_v[0]),
        .nack(nack_v[0]), .scl(scl_v[0]), .sda(sda)
    );

    cam_i2c_master #(.DATA_BYTES(2)) u_b (
        .pixclk(pixclk), .reset(reset), .start(start_b), .rw(rw),
        .slave_addr(addr), .register_in(reg_in), .datain(din),
        .dataout(dout_b), .busy(busy_v[1]), .done(done_v[1]),
        .nack(nack_v[1]), .scl(scl_v[1]), .sda(sda)
    );

    cam_i2c_master #(.CLK_HZ(50_000_000), .I2C_HZ(100_000)) u_c (
        .pixclk(pixclk), .reset(reset), .start(start_c), .rw(rw),
        .slave_addr(addr), .register_in(reg_in), .datain(din[7:0]),
        .dataout(dout_c), .busy(busy_v[2]), .done(done_v[2]),
        .nack(nack_v[2]), .scl(scl_v[2]), .sda(sda)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int sel = 0;
    int log_q[$];
    int exp_q[$];
    int rise_q[$];
    int exp_dout[3];

    // slave model state
    logic        ps = 1'b1, pd = 1'b1;
    int          bitn = 0, wr_cnt = 0, rbit = 0, nack_at = -1;
    logic        first = 1'b0, reading = 1'b0, ackv = 1'b1;
    logic [7:0]  sh = '0;
    logic [31:0] rd_word = '0;

    always @(posedge pixclk) cyc <= cyc + 1;

    always @(negedge pixclk) begin
        logic s, d;
        s = scl_v[sel];
        d = sda;
        if (!reset) begin
            s_low = 1'b0;
            bitn = 0;
            reading = 1'b0;
        end else if (ps && s && pd && !d) begin
            log_q.push_back(EV_S);
            bitn = 0; first = 1'b1; reading = 1'b0; s_low = 1'b0;
        end else if (ps && s && !pd && d) begin
            log_q.push_back(EV_P);
            bitn = 0; reading = 1'b0; s_low = 1'b0;
        end else if (!ps && s) begin
            rise_q.push_back(cyc);
            if (bitn < 8) sh = {sh[6:0], d};
            else ackv = d;
            bitn++;
        end else if (ps && !s) begin
            if (bitn == 8) begin
                if (!reading) begin
                    log_q.push_back(int'(sh));
                    s_low = (wr_cnt != nack_at);
                    wr_cnt++;
                end else begin
                    s_low = 1'b0;
                end
            end else if (bitn == 9) begin
                bitn = 0;
                if (reading) log_q.push_back(ackv ? EV_MN : EV_MA);
                if (first) begin
                    first = 1'b0;
                    reading = sh[0];
                end
                if (reading && !ackv) begin
                    s_low = !rd_word[31-rbit];
                    rbit++;
                end else begin
                    s_low = 1'b0;
                end
            end else if (reading && bitn < 8) begin
                s_low = !rd_word[31-rbit];
                rbit++;
            end
        end
        ps = s;
        pd = d;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int dout_of(input int s);
        case (s)
            0: return int'(dout_a);
            1: return int'(dout_b);
            default: return int'(dout_c);
        endcase
    endfunction

    task automatic set_start(input int s, input logic v);
        case (s)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    // expected bus events and bit-time count from the transaction rules
    task automatic build_exp(input logic r, input logic [6:0] a,
                             input logic [15:0] rg, input logic [31:0] dv,
                             input int ndat, input int nk, output int n);
        int wb[$];
        exp_q.delete();
        wb.push_back(int'({a, 1'b0}));
        for (int i = 1; i >= 0; i--) wb.push_back(int'((rg >> (8*i)) & 16'hFF));
        if (!r) begin
            for (int i = ndat-1; i >= 0; i--)
                wb.push_back(int'((dv >> (8*i)) & 32'hFF));
        end else begin
            wb.push_back(int'({a, 1'b1}));
        end
        exp_q.push_back(EV_S);
        for (int i = 0; i < wb.size(); i++) begin
            if (r && i == 3) exp_q.push_back(EV_S);
            exp_q.push_back(wb[i]);
            if (i == nk) begin
                exp_q.push_back(EV_P);
                n = 2 + 9*(i+1) + ((r && i > 2) ? 1 : 0);
                return;
            end
        end
        if (r) for (int i = 0; i < ndat; i++)
            exp_q.push_back(i == ndat-1 ? EV_MN : EV_MA);
        exp_q.push_back(EV_P);
        n = r ? 3 + 9*(2 + 2 + ndat) : 2 + 9*(1 + 2 + ndat);
    endtask

    task automatic run_txn(input int s, input logic r, input logic [6:0] a,
                           input logic [15:0] rg, input logic [31:0] dv,
                           input int nk, input logic [31:0] rv, input int lat,
                           input logic hold, input int glitch, input string nm);
        int n, cnt, ndat, div, mism;
        ndat = (s == 1) ? 2 : 1;
        div  = (s == 2) ? 125 : 16;
        build_exp(r, a, rg, dv, ndat, nk, n);
        if (lat < 0) lat = 4 * div * n;
        sel = s; rw = r; addr = a; reg_in = rg; din = dv[15:0];
        nack_at = nk;
        rd_word = rv << (32 - 8*ndat);
        wr_cnt = 0; rbit = 0;
        log_q.delete(); rise_q.delete();
        @(negedge pixclk);
        set_start(s, 1'b1);
        @(posedge pixclk);
        #1;
        set_start(s, hold);
        chk({nm, "_busy_rise"}, busy_v[s], 1);
        chk({nm, "_nack_clr"}, nack_v[s], 0);
        cnt = 0;
        while (cnt < lat + 100) begin
            @(posedge pixclk);
            #1;
            cnt++;
            if (glitch > 0 && cnt == glitch) begin
                set_start(s, 1'b1);
                rw = ~r; addr = ~a; reg_in = ~rg; din = ~dv[15:0];
            end else if (glitch > 0 && cnt == glitch + 1) begin
                set_start(s, 1'b0);
            end
            if (done_v[s]) break;
        end
        chk({nm, "_latency"}, cnt, lat);
        chk({nm, "_busy_fall"}, busy_v[s], 0);
        chk({nm, "_nack"}, nack_v[s], (nk >= 0) ? 1 : 0);
        if (r && nk < 0) exp_dout[s] = int'(rv & ((ndat == 2) ? 32'hFFFF : 32'hFF));
        chk({nm, "_dataout"}, dout_of(s), exp_dout[s]);
        mism = (log_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            if (log_q[i] != exp_q[i]) mism++;
        chk({nm, "_bus_seq"}, mism, 0);
    endtask

    typedef struct {
        int          s;
        logic        r;
        logic [6:0]  a;
        logic [15:0] rg;
        logic [31:0] dv;
        int          nk;
        logic [31:0] rv;
        int          lat;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{0, 1'b0, 7'h10, 16'h0100, 32'h01,   -1, 32'h0,    2432};
        tbl[1] = '{1, 1'b1, 7'h50, 16'h300A, 32'h0,    -1, 32'h5634, 3648};
        tbl[2] = '{1, 1'b1, 7'h50, 16'h1234, 32'h0,     2, 32'hBEEF, 1856};
        tbl[3] = '{1, 1'b0, 7'h21, 16'h1234, 32'hBEEF, -1, 32'h0,    3008};
        tbl[4] = '{0, 1'b1, 7'h3C, 16'hABCD, 32'h0,     0, 32'h77,   704};

        start_a = 0; start_b = 0; start_c = 0;
        rw = 0; addr = '0; reg_in = '0; din = '0;
        for (int i = 0; i < 3; i++) exp_dout[i] = 0;
        reset = 1'b0;
        repeat (3) @(posedge pixclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_scl", scl_v[i], 1);
            chk("rst_busy", busy_v[i], 0);
            chk("rst_done", done_v[i], 0);
            chk("rst_nack", nack_v[i], 0);
            chk("rst_dout", dout_of(i), 0);
        end
        chk("rst_sda", sda, 1);
        @(negedge pixclk);
        reset = 1'b1;
        repeat (2) @(posedge pixclk);

        for (int i = 0; i < 5; i++)
            run_txn(tbl[i].s, tbl[i].r, tbl[i].a, tbl[i].rg, tbl[i].dv,
                    tbl[i].nk, tbl[i].rv, tbl[i].lat, 1'b0, 0, $sformatf("vec%0d", i));

        // start pulsed mid-transfer with different fields
        run_txn(0, 1'b0, 7'h42, 16'h5A5A, 32'hC3, -1, 32'h0, 2432, 1'b0, 700, "glitch");

        // start held high: second transfer accepted right after done
        run_txn(0, 1'b0, 7'h11, 16'h0203, 32'h04, -1, 32'h0, 2432, 1'b1, 0, "b2b_1");
        run_txn(0, 1'b0, 7'h11, 16'h0203, 32'h04, -1, 32'h0, 2432, 1'b0, 0, "b2b_2");

        // reset in the middle of a write data byte
        sel = 0; rw = 0; addr = 7'h33; reg_in = 16'h4455; din = 16'h00F0;
        nack_at = -1; wr_cnt = 0; rbit = 0;
        @(negedge pixclk);
        start_a = 1'b1;
        @(posedge pixclk);
        #1;
        start_a = 1'b0;
        repeat (4 * 16 * 31) @(posedge pixclk);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_scl", scl_v[0], 1);
        chk("mid_rst_sda", sda, 1);
        chk("mid_rst_busy", busy_v[0], 0);
        chk("mid_rst_done", done_v[0], 0);
        chk("mid_rst_nack", nack_v[0], 0);
        chk("mid_rst_dout_b", dout_of(1), 0);
        for (int i = 0; i < 3; i++) exp_dout[i] = 0;
        @(negedge pixclk);
        reset = 1'b1;
        repeat (2) @(posedge pixclk);
        run_txn(0, 1'b0, 7'h33, 16'h4455, 32'hF0, -1, 32'h0, 2432, 1'b0, 0, "post_rst");

        for (int i = 0; i < 6; i++) begin
            int s, nk, maxk;
            logic r;
            s = $urandom_range(0, 1);
            r = 1'($urandom_range(0, 1));
            maxk = r ? 3 : 2 + ((s == 1) ? 2 : 1);
            nk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, maxk) : -1;
            run_txn(s, r, 7'($urandom), 16'($urandom), $urandom, nk, $urandom,
                    -1, 1'b0, 0, $sformatf("rnd%0d", i));
        end

        // slow bus: divider of 125
        run_txn(2, 1'b0, 7'h10, 16'h0100, 32'h01, -1, 32'h0, 19000, 1'b0, 0, "div125");
        if (rise_q.size() >= 3) chk("scl_period", rise_q[2] - rise_q[1], 500);
        else chk("scl_rises", rise_q.size(), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
